// File: rtl/wireless_pkg.sv
// Shared types and UART framing constants for the wireless
// command transmitter and its byte serialiser.
package wireless_pkg;

  typedef enum logic [2:0] {
    WL_IDLE,
    WL_GUARD_PRE,
    WL_SEND,
    WL_GUARD_POST,
    WL_FINISH
  } wl_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   FRAME_BITS = 10;

endpackage

// File: rtl/wireless_cmd_tx_uart.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit.
// Each bit lasts BAUD_DIV clocks; line is registered and idles high.
module uart_tx_byte
  import wireless_pkg::*;
#(
  parameter int BAUD_DIV = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [3:0] IDX_LAST = 4'(FRAME_BITS - 1);
  localparam logic [3:0] IDX_STOP = 4'(FRAME_BITS - 2);

  logic          active;
  logic [CW-1:0] cnt;
  logic [3:0]    idx;
  logic [7:0]    shreg;
  logic          tx_q;

  assign ready = !active;
  assign tx    = tx_q;

  // Load a byte, then step through the frame one bit time at a time
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active <= 1'b0;
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      tx_q   <= STOP_BIT;
    end else if (!active) begin
      if (valid) begin
        active <= 1'b1;
        cnt    <= '0;
        idx    <= '0;
        shreg  <= data;
        tx_q   <= START_BIT;
      end
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_ONE;
    end else begin
      cnt <= '0;
      if (idx == IDX_LAST) begin
        active <= 1'b0;
      end else begin
        idx <= idx + 4'd1;
        if (idx == IDX_STOP) begin
          tx_q <= STOP_BIT;
        end else begin
          tx_q  <= shreg[0];
          shreg <= {1'b1, shreg[7:1]};
        end
      end
    end
  end

endmodule

// File: rtl/wireless_cmd_tx.sv
// Puts the wireless module into command mode, streams command bytes
// as UART 8N1 on its RX pin, then releases command mode after a guard.
module wireless_cmd_tx
  import wireless_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 9600,
  parameter int GUARD_CYCLES = 4_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_start,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       wireless_rx,
  output logic       wireless_set,
  output logic       busy,
  output logic       done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
  localparam logic [GW-1:0] GUARD_ONE  = GW'(1);

  wl_state_t     state;
  wl_state_t     state_nxt;
  logic [GW-1:0] guard_cnt;
  logic          last_acc;
  logic          ser_ready;
  logic          send_open;
  logic          frame_end;
  logic          guard_done;

  assign send_open  = (state == WL_SEND) && !last_acc;
  assign s_ready    = send_open && ser_ready;
  assign frame_end  = (state == WL_SEND) && last_acc && ser_ready;
  assign guard_done = (guard_cnt == GUARD_LAST);

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_ser (
    .clk     (clk),
    .reset_n (reset_n),
    .data    (s_data),
    .valid   (send_open && s_valid),
    .ready   (ser_ready),
    .tx      (wireless_rx)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= WL_IDLE;
    else          state <= state_nxt;
  end

  // Sequence: pre-guard, stream bytes, post-guard, one-cycle finish
  always_comb begin
    state_nxt = state;
    unique case (state)
      WL_IDLE:       if (cmd_start)  state_nxt = WL_GUARD_PRE;
      WL_GUARD_PRE:  if (guard_done) state_nxt = WL_SEND;
      WL_SEND:       if (frame_end)  state_nxt = WL_GUARD_POST;
      WL_GUARD_POST: if (guard_done) state_nxt = WL_FINISH;
      WL_FINISH:     state_nxt = WL_IDLE;
      default:       state_nxt = WL_IDLE;
    endcase
  end

  // Pin and status decode from the current state
  always_comb begin
    wireless_set = 1'b1;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (1'b1)
      (state == WL_GUARD_PRE),
      (state == WL_SEND),
      (state == WL_GUARD_POST): begin
        wireless_set = 1'b0;
        busy         = 1'b1;
      end
      (state == WL_FINISH): done = 1'b1;
      default: ;
    endcase
  end

  // Guard timer; the idle cycle after the last stop bit is guard clock 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      guard_cnt <= '0;
    end else begin
      unique case (state)
        WL_GUARD_PRE,
        WL_GUARD_POST: guard_cnt <= guard_cnt + GUARD_ONE;
        WL_SEND:       guard_cnt <= frame_end ? GUARD_ONE : '0;
        default:       guard_cnt <= '0;
      endcase
    end
  end

  // Remember that the final byte of the command has been taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 last_acc <= 1'b0;
    else if (state == WL_IDLE)    last_acc <= 1'b0;
    else if (s_ready && s_valid)  last_acc <= s_last;
  end

endmodule

// File: tb/tb_wireless_cmd_tx.sv
// Directed bench for wireless_cmd_tx with BAUD_DIV=10, GUARD_CYCLES=20.
// Expected pin timelines are built from the frame timing, per cycle.
module tb_wireless_cmd_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_start;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic       wireless_rx;
  logic       wireless_set;
  logic       busy;
  logic       done;

  int vectors = 0;
  int miscompares = 0;

  wireless_cmd_tx #(
    .CLK_FREQ     (1000),
    .BAUD         (100),
    .GUARD_CYCLES (20)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_start    (cmd_start),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .wireless_rx  (wireless_rx),
    .wireless_set (wireless_set),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int cyc,
                     input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int cyc);
    chk({tag, "_rx"},    cyc, wireless_rx,  1'b1);
    chk({tag, "_set"},   cyc, wireless_set, 1'b1);
    chk({tag, "_busy"},  cyc, busy,         1'b0);
    chk({tag, "_ready"}, cyc, s_ready,      1'b0);
    chk({tag, "_done"},  cyc, done,         1'b0);
  endtask

  // One command of n bytes (n<=3). stall delays s_valid past the first
  // s_ready; poke pulses cmd_start mid-SEND and on the FINISH cycle.
  task automatic run_seq(input string tag,
                         input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input int n,
                         input int stall, input bit poke,
                         input int tail);
    logic [7:0] bq[3];
    int hs[3];
    int d_cyc;
    int i;
    int j;
    logic e_rx, e_set, e_busy, e_done, e_rdy;
    bq[0] = b0;
    bq[1] = b1;
    bq[2] = b2;
    for (int k = 0; k < 3; k++) hs[k] = 21 + stall + 101 * k;
    d_cyc = hs[n-1] + 121;
    tick();
    cmd_start = 1'b1;
    s_valid   = (stall == 0);
    s_data    = (stall == 0) ? bq[0] : 8'hFF;
    s_last    = (stall == 0) && (n == 1);
    chk({tag, "_t0_set"},  0, wireless_set, 1'b1);
    chk({tag, "_t0_busy"}, 0, busy,         1'b0);
    for (int c = 1; c <= d_cyc + tail; c++) begin
      tick();
      cmd_start = poke && (c == 50 || c == d_cyc);
      i = 0;
      for (int k = 0; k < n; k++) if (hs[k] < c) i++;
      if (i >= n) begin
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
      end else if (c < hs[0]) begin
        s_valid = 1'b0;
        s_data  = 8'hFF;
        s_last  = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = bq[i];
        s_last  = (i == n - 1);
      end
      e_rx = 1'b1;
      for (int k = 0; k < n; k++) begin
        if (c > hs[k] && c <= hs[k] + 100) begin
          j = (c - hs[k] - 1) / 10;
          if (j == 0)      e_rx = 1'b0;
          else if (j == 9) e_rx = 1'b1;
          else             e_rx = bq[k][j-1];
        end
      end
      e_busy = (c < d_cyc);
      e_set  = !e_busy;
      e_done = (c == d_cyc);
      e_rdy  = (c >= 21 && c <= hs[0]);
      for (int k = 1; k < n; k++) if (c == hs[k]) e_rdy = 1'b1;
      chk({tag, "_rx"},    c, wireless_rx,  e_rx);
      chk({tag, "_set"},   c, wireless_set, e_set);
      chk({tag, "_busy"},  c, busy,         e_busy);
      chk({tag, "_done"},  c, done,         e_done);
      chk({tag, "_ready"}, c, s_ready,      e_rdy);
    end
    cmd_start = 1'b0;
    s_valid   = 1'b0;
    s_last    = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    cmd_start = 1'b0;
    s_data    = 8'h00;
    s_valid   = 1'b0;
    s_last    = 1'b0;

    // Reset and idle
    repeat (3) tick();
    chk_idle("rst", 0);
    reset_n = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      chk_idle("idle", c);
    end

    // Single byte 'A'
    run_seq("one", 8'h41, 8'h00, 8'h00, 1, 0, 1'b0, 5);

    // "AT\r" back to back
    run_seq("at", 8'h41, 8'h54, 8'h0D, 3, 0, 1'b0, 5);

    // Source stalls 50 cycles after s_ready rises
    run_seq("stall", 8'h55, 8'h00, 8'h00, 1, 50, 1'b0, 5);

    // cmd_start during SEND and on FINISH is ignored
    run_seq("poke", 8'hA5, 8'h00, 8'h00, 1, 0, 1'b1, 5);

    // A start on the IDLE cycle right after FINISH is accepted
    run_seq("chain_a", 8'h3C, 8'h00, 8'h00, 1, 0, 1'b0, 0);
    run_seq("chain_b", 8'hC3, 8'h00, 8'h00, 1, 0, 1'b0, 5);

    // Reset during data bit 3 of 0x41 (line low there)
    tick();
    cmd_start = 1'b1;
    s_data    = 8'h41;
    s_valid   = 1'b1;
    s_last    = 1'b1;
    tick();
    cmd_start = 1'b0;
    repeat (64) tick();
    chk("mid_rx_pre",  65, wireless_rx,  1'b0);
    chk("mid_set_pre", 65, wireless_set, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rx_async",  65, wireless_rx,  1'b1);
    chk("mid_set_async", 65, wireless_set, 1'b1);
    chk("mid_busy",      65, busy,         1'b0);
    chk("mid_ready",     65, s_ready,      1'b0);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk_idle("post_rst", c);
    end
    run_seq("fresh", 8'h0D, 8'h00, 8'h00, 1, 0, 1'b0, 5);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
